// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency word memory between
// the instruction-fetch (IF) and data-memory (DM) requesters of the pipeline.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP; DM normally wins arbitration,
// but IF is guaranteed a grant after MAX_STREAK consecutive DM grants.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i                       enables new grants
//   if_req_i/if_addr_i            IF read request (held until if_ack_o)
//   if_ack_o/if_rdata_o           IF completion pulse and instruction word
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  DM request (held until dm_ack_o)
//   dm_ack_o/dm_rdata_o           DM completion pulse and read data (0 on writes)
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  memory strobe, one cycle per access
//   mem_rdata_i                   memory read data, valid MEM_LAT cycles after strobe
//   stall_o                       combinational: a request is pending and not acked
//   busy_o                        FSM is not IDLE
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        busy_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_grant;
  logic           w_grant_dm;
  logic           w_capture;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_streak;
  logic           r_own_dm;
  logic           r_we;
  logic           r_if_ack;
  logic           r_dm_ack;
  logic [DW-1:0]  r_if_rdata;
  logic [DW-1:0]  r_dm_rdata;
  logic           r_mem_en;
  logic           r_mem_we;
  logic [AW-1:0]  r_mem_addr;
  logic [DW-1:0]  r_mem_wdata;
  logic           r_busy;
  logic           w_unused;

  // Byte-offset bits are dropped: the memory is word addressed.
  assign w_unused = ^{if_addr_i[1:0], dm_addr_i[1:0]};

  // Next-state and arbitration decision.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_dm  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && (if_req_i || dm_req_i)) begin
          w_grant     = 1'b1;
          // DM wins unless IF has been starved for MAX_STREAK grants.
          w_grant_dm  = dm_req_i && !(if_req_i && (r_streak == CW'(MAX_STREAK)));
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: latch at grant, strobe memory in ISSUE, capture and ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_streak    <= '0;
      r_own_dm    <= 1'b0;
      r_we        <= 1'b0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= (w_state_nxt != S_IDLE);

      if (w_grant) begin
        r_own_dm <= w_grant_dm;
        r_we     <= w_grant_dm && dm_we_i;
        r_mem_en <= 1'b1;
        r_mem_we <= w_grant_dm && dm_we_i;
        if (w_grant_dm) begin
          r_mem_addr  <= {dm_addr_i[AW-1:2], 2'b00};
          r_mem_wdata <= dm_wdata_i;
          if (!if_req_i) begin
            r_streak <= '0;
          end else if (r_streak != CW'(MAX_STREAK)) begin
            r_streak <= r_streak + 1'b1;
          end
        end else begin
          r_mem_addr <= {if_addr_i[AW-1:2], 2'b00};
          r_streak   <= '0;
        end
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= CW'(MEM_LAT - 1);
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_capture) begin
        if (r_own_dm) begin
          r_dm_rdata <= r_we ? '0 : mem_rdata_i;
          r_dm_ack   <= 1'b1;
        end else begin
          r_if_rdata <= mem_rdata_i;
          r_if_ack   <= 1'b1;
        end
      end
    end
  end

  assign if_ack_o    = r_if_ack;
  assign if_rdata_o  = r_if_rdata;
  assign dm_ack_o    = r_dm_ack;
  assign dm_rdata_o  = r_dm_rdata;
  assign mem_en_o    = r_mem_en;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign busy_o      = r_busy;
  assign stall_o     = (if_req_i && !r_if_ack) || (dm_req_i && !r_dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed sequences, a vector table of single
// transactions, and randomized traffic checked every cycle against a
// transaction-level reference model with its own copy of memory.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned MAX_STREAK = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        busy_o;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory seen by the DUT and the reference model's independent copy.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          rd_cnt = 0;
  logic [7:0]  rd_idx = '0;

  // Snapshot of DUT outputs taken mid-cycle.
  logic        s_if_ack, s_dm_ack, s_en, s_we, s_stall, s_busy;
  logic [31:0] s_if_rd, s_dm_rd, s_addr, s_wdata;

  // Transaction-level reference model.
  bit          m_busy = 1'b0;
  bit          m_dm, m_we;
  logic [31:0] m_addr, m_wdata, m_rd;
  int          m_iss, m_ack, m_free = 0, m_streak = 0;
  logic [31:0] e_if_rd = '0, e_dm_rd = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endfunction

  task automatic model_check();
    bit          e_if_ack, e_dm_ack, e_en, e_busy, e_stall, take_if;
    logic [7:0]  idx;
    e_if_ack = m_busy && (cyc == m_ack) && !m_dm;
    e_dm_ack = m_busy && (cyc == m_ack) && m_dm;
    e_en     = m_busy && (cyc == m_iss);
    e_busy   = m_busy && (cyc >= m_iss);
    e_stall  = (if_req_i && !e_if_ack) || (dm_req_i && !e_dm_ack);
    if (e_if_ack) e_if_rd = m_rd;
    if (e_dm_ack) e_dm_rd = m_rd;
    chk("m_if_ack",   32'(s_if_ack), 32'(e_if_ack));
    chk("m_dm_ack",   32'(s_dm_ack), 32'(e_dm_ack));
    chk("m_if_rdata", s_if_rd, e_if_rd);
    chk("m_dm_rdata", s_dm_rd, e_dm_rd);
    chk("m_mem_en",   32'(s_en), 32'(e_en));
    chk("m_mem_we",   32'(s_we), e_en ? 32'(m_we) : 32'd0);
    chk("m_mem_addr", s_addr, e_en ? m_addr : 32'd0);
    chk("m_mem_wdata", s_wdata, e_en ? m_wdata : 32'd0);
    chk("m_busy",     32'(s_busy), 32'(e_busy));
    chk("m_stall",    32'(s_stall), 32'(e_stall));
    if (e_en) begin
      idx  = m_addr[9:2];
      m_rd = m_we ? 32'd0 : ref_mem[idx];
      if (m_we) ref_mem[idx] = m_wdata;
    end
    if (e_if_ack || e_dm_ack) begin
      m_busy = 1'b0;
      m_free = cyc + 1;
    end
    if (rst_i) begin
      m_busy   = 1'b0;
      m_streak = 0;
      e_if_rd  = '0;
      e_dm_rd  = '0;
      m_free   = cyc + 1;
    end else if (!m_busy && cyc >= m_free && start_i && (if_req_i || dm_req_i)) begin
      take_if = if_req_i && (!dm_req_i || m_streak == int'(MAX_STREAK));
      if (take_if)       m_streak = 0;
      else if (if_req_i) m_streak = (m_streak + 1 > int'(MAX_STREAK)) ? int'(MAX_STREAK) : m_streak + 1;
      else               m_streak = 0;
      m_dm    = !take_if;
      m_we    = m_dm && dm_we_i;
      m_addr  = m_dm ? {dm_addr_i[31:2], 2'b00} : {if_addr_i[31:2], 2'b00};
      m_wdata = m_dm ? dm_wdata_i : 32'd0;
      m_iss   = cyc + 1;
      m_ack   = cyc + 2 + int'(MEM_LAT);
      m_busy  = 1'b1;
    end
  endtask

  // Completes the current cycle: sample, check, run memory, advance.
  task automatic step();
    @(negedge clk);
    s_if_ack = if_ack_o;  s_dm_ack = dm_ack_o;
    s_if_rd  = if_rdata_o; s_dm_rd = dm_rdata_o;
    s_en = mem_en_o; s_we = mem_we_o; s_addr = mem_addr_o; s_wdata = mem_wdata_o;
    s_stall = stall_o; s_busy = busy_o;
    model_check();
    mem_rdata_i = 32'hBAD0_0000 ^ 32'(cyc);
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) mem_rdata_i = mem[rd_idx];
    end
    if (mem_en_o) begin
      rd_idx = mem_addr_o[9:2];
      rd_cnt = int'(MEM_LAT);
      if (mem_we_o) mem[rd_idx] = mem_wdata_o;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; start_i = 1'b1;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int id);
    int ack_k;
    ack_k = -1;
    if (v.dm) begin
      dm_req_i = 1'b1; dm_we_i = v.we; dm_addr_i = v.addr; dm_wdata_i = v.wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = v.addr;
    end
    for (int k = 0; k < 12 && ack_k < 0; k++) begin
      step();
      chk($sformatf("vec%0d_mem_we", id), 32'(s_we), 32'(k == 1 && v.dm && v.we));
      if (k == 1) begin
        chk($sformatf("vec%0d_mem_en", id), 32'(s_en), 32'd1);
        chk($sformatf("vec%0d_mem_addr", id), s_addr, {v.addr[31:2], 2'b00});
      end
      if (v.dm ? s_dm_ack : s_if_ack) ack_k = k;
    end
    chk($sformatf("vec%0d_latency", id), 32'(ack_k), 32'(2 + MEM_LAT));
    chk($sformatf("vec%0d_rdata", id), v.dm ? s_dm_rd : s_if_rd, v.exp_rdata);
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    logic [5:0]  order;
    int          g;
    bit          got;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h08, 32'h2A,       32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h08, 32'h0,        32'h2A};
    vecs[3] = '{1'b1, 1'b0, 32'h0B, 32'h0,        32'h2A};
    vecs[4] = '{1'b0, 1'b0, 32'h0A, 32'h0,        32'h2A};
    vecs[5] = '{1'b1, 1'b1, 32'h3C, 32'hFFFFFFFF, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h3D, 32'h0,        32'hFFFFFFFF};
    vecs[7] = '{1'b1, 1'b0, 32'h04, 32'h0,        32'h11111111};

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA5A5_0000 | 32'(i);
      ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    mem[1] = 32'h11111111; ref_mem[1] = 32'h11111111;

    rst_i = 1'b1; start_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_rdata_i = '0;
    @(posedge clk);
    #1;

    // Reset state.
    step();
    rst_i = 1'b0;
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_mem_en", 32'(s_en), 32'd0);
    chk("rst_if_rdata", s_if_rd, 32'd0);

    // Single IF read of an unaligned address.
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h12;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("s1_stall", 32'(s_stall), 32'(k < 4));
      chk("s1_if_ack", 32'(s_if_ack), 32'(k == 4));
      if (k == 1) begin
        chk("s1_mem_en", 32'(s_en), 32'd1);
        chk("s1_mem_addr", s_addr, 32'h10);
      end
      if (k == 4) chk("s1_if_rdata", s_if_rd, 32'hDEADBEEF);
    end
    if_req_i = 1'b0;

    // Simultaneous IF and DM: DM first, IF right after.
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h10;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h04;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("s2_dm_ack", 32'(s_dm_ack), 32'(k == 4));
      chk("s2_if_ack", 32'(s_if_ack), 32'(k == 9));
      if (k == 4) begin
        chk("s2_dm_rdata", s_dm_rd, 32'h11111111);
        dm_req_i = 1'b0;
      end
      if (k == 6) chk("s2_if_issue_addr", s_en ? s_addr : 32'hFFFF_FFFF, 32'h10);
      if (k == 9) chk("s2_if_rdata", s_if_rd, 32'hDEADBEEF);
    end
    if_req_i = 1'b0;

    // Starvation guard: both held high, grant pattern DM DM IF repeats.
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h10;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h04;
    g = 0; order = '0;
    for (int k = 0; k < 60 && g < 6; k++) begin
      step();
      if (s_en) begin
        order[g] = (s_addr == 32'h04);
        g++;
      end
    end
    chk("s3_grants", 32'(g), 32'd6);
    chk("s3_order", 32'(order), 32'(6'b011011));
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      got = s_if_ack;
    end
    chk("s3_last_if_ack", 32'(got), 32'd1);
    if_req_i = 1'b0; dm_req_i = 1'b0;

    // Single-transaction vector table, including write then read-back.
    do_reset();
    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // Reset during WAIT aborts the read; it re-arbitrates afterwards.
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h10;
    step();
    step();
    rst_i = 1'b1;
    step();
    chk("s5_no_ack_wait", 32'(s_if_ack), 32'd0);
    rst_i = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 0) begin
        chk("s5_busy_zero", 32'(s_busy), 32'd0);
        chk("s5_en_zero", 32'(s_en), 32'd0);
        chk("s5_addr_zero", s_addr, 32'd0);
        chk("s5_rdata_zero", s_if_rd, 32'd0);
      end
      chk("s5_if_ack", 32'(s_if_ack), 32'(j == 4));
      if (s_if_ack) if_req_i = 1'b0;
    end
    if_req_i = 1'b0;

    // start_i low holds off grants; raising it starts a normal transaction.
    do_reset();
    start_i = 1'b0;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h10;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("s6_hold_en", 32'(s_en), 32'd0);
      chk("s6_hold_stall", 32'(s_stall), 32'd1);
    end
    start_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("s6_mem_en", 32'(s_en), 32'(j == 1));
      chk("s6_dm_ack", 32'(s_dm_ack), 32'(j == 4));
    end
    chk("s6_dm_rdata", s_dm_rd, 32'hDEADBEEF);
    dm_req_i = 1'b0;

    // Randomized traffic; the reference model checks every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (if_req_i && s_if_ack) if_req_i = 1'b0;
      else if (!if_req_i && ($urandom % 4) == 0) begin
        if_req_i = 1'b1; if_addr_i = $urandom;
      end
      if (dm_req_i && s_dm_ack) begin
        dm_req_i = 1'b0; dm_we_i = 1'b0;
      end else if (!dm_req_i && ($urandom % 3) == 0) begin
        dm_req_i = 1'b1; dm_we_i = 1'($urandom % 2);
        dm_addr_i = $urandom; dm_wdata_i = $urandom;
      end
      start_i = (($urandom % 8) != 0);
      rst_i   = (($urandom % 300) == 0);
      step();
    end
    rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
